// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with byte-lane writes, optional fixed wait states and a
// two-cycle ERROR response for out-of-range, oversize or misaligned transfers.
module ahb_sram_slave #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           DEPTH_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA
);

   localparam int unsigned NB        = DATA_WIDTH / 8;
   localparam int unsigned LANE_BITS = $clog2(NB);
   localparam int unsigned IDX_BITS  = $clog2(DEPTH_WORDS);
   localparam logic [63:0] MEM_BYTES = 64'(DEPTH_WORDS) * 64'(NB);
   localparam logic [2:0]  CNT_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t                state, state_nx;
   logic [2:0]            cnt, cnt_nx;
   logic                  pend, pend_nx;
   logic                  d_write, wr_nx;
   logic [IDX_BITS-1:0]   d_idx, idx_nx;
   logic [NB-1:0]         d_strb, strb_nx;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   logic [ADDR_WIDTH-1:0] offset;
   logic                  accept;
   logic                  addr_err;
   logic [LANE_BITS-1:0]  align_mask;
   logic [LANE_BITS-1:0]  lane;
   logic [NB-1:0]         strb;
   logic                  wr_en;
   logic                  rd_en;
   logic                  unused_ok;

   always_comb begin
      unused_ok  = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
      offset     = HADDR - BASE_ADDR;
      accept     = HSEL && HREADY && HTRANS[1];
      align_mask = ~({LANE_BITS{1'b1}} << HSIZE);
      addr_err   = (HADDR < BASE_ADDR) || (64'(offset) >= MEM_BYTES) ||
                   (HSIZE > 3'(LANE_BITS)) ||
                   ((HADDR[LANE_BITS-1:0] & align_mask) != '0);
      // a lane is selected when it lies in the same size-aligned block as HADDR
      strb = '0;
      lane = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         lane    = i[LANE_BITS-1:0];
         strb[i] = ((lane >> HSIZE) == (HADDR[LANE_BITS-1:0] >> HSIZE));
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pend    <= 1'b0;
         d_write <= 1'b0;
         d_idx   <= '0;
         d_strb  <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         pend    <= pend_nx;
         d_write <= wr_nx;
         d_idx   <= idx_nx;
         d_strb  <= strb_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pend_nx  = pend;
      wr_nx    = d_write;
      idx_nx   = d_idx;
      strb_nx  = d_strb;
      case (state)
         ST_WAIT: begin
            if (cnt == '0) state_nx = ST_IDLE;
            else           cnt_nx   = cnt - 3'd1;
         end
         ST_ERR1: state_nx = ST_ERR2;
         default: begin
            // IDLE and ERR2 both end the current data phase on this edge
            state_nx = ST_IDLE;
            pend_nx  = 1'b0;
            if (accept) begin
               if (addr_err) begin
                  state_nx = ST_ERR1;
               end else begin
                  pend_nx = 1'b1;
                  wr_nx   = HWRITE;
                  idx_nx  = offset[IDX_BITS+LANE_BITS-1 -: IDX_BITS];
                  strb_nx = strb;
                  if (WAIT_STATES > 0) begin
                     state_nx = ST_WAIT;
                     cnt_nx   = CNT_LOAD;
                  end
               end
            end
         end
      endcase
   end

   always_comb begin
      HREADYOUT = (state != ST_WAIT) && (state != ST_ERR1);
      HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
      wr_en     = pend && d_write && (state == ST_IDLE);
      rd_en     = pend && !d_write && (state == ST_IDLE);
      // combinational read after the previous edge's commit avoids any RAW hazard
      HRDATA    = rd_en ? mem[d_idx] : '0;
   end

   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (d_strb[i]) mem[d_idx][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait instance at base 0 and one
// three-wait-state instance at base 0x2000_0000 share the address bus.
module tb_ahb_sram_slave;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsel0 = 1'b0, hsel3 = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = T_IDLE;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd2;
   logic [2:0]  hburst = '0;
   logic [3:0]  hprot = '0;
   logic        hmastlock = 1'b0;
   logic [31:0] hwdata = '0;
   logic        ready0, resp0, ready3, resp3;
   logic [31:0] rdata0, rdata3;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024),
                    .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_ws0 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HMASTLOCK(hmastlock), .HREADY(ready0), .HWDATA(hwdata),
      .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0));

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024),
                    .BASE_ADDR(32'h2000_0000), .WAIT_STATES(3)) u_ws3 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HMASTLOCK(hmastlock), .HREADY(ready3), .HWDATA(hwdata),
      .HREADYOUT(ready3), .HRESP(resp3), .HRDATA(rdata3));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz);
      hsel0  = (d == 0);
      hsel3  = (d == 3);
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      htrans = T_NONSEQ;
   endtask

   task automatic idle;
      hsel0  = 1'b0;
      hsel3  = 1'b0;
      htrans = T_IDLE;
      hwrite = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick; tick;
      nvec++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL rst_ready0: got %b want 1", ready0); end
      nvec++; if (resp0 !== 1'b0) begin nerr++; $display("FAIL rst_resp0: got %b want 0", resp0); end
      nvec++; if (rdata0 !== 32'h0) begin nerr++; $display("FAIL rst_rdata0: got %h want 0", rdata0); end
      nvec++; if (ready3 !== 1'b1) begin nerr++; $display("FAIL rst_ready3: got %b want 1", ready3); end
      nvec++; if (resp3 !== 1'b0) begin nerr++; $display("FAIL rst_resp3: got %b want 0", resp3); end
      rst_n = 1'b1;
   endtask

   task automatic test_write_read;
      drive(0, 32'h10, 1'b1, 3'd2);
      tick;
      hwdata = 32'hDEAD_BEEF;
      drive(0, 32'h10, 1'b0, 3'd2);
      nvec++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL wr_ready: got %b want 1", ready0); end
      tick;
      idle();
      nvec++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL rd_ready: got %b want 1", ready0); end
      nvec++; if (resp0 !== 1'b0) begin nerr++; $display("FAIL rd_resp: got %b want 0", resp0); end
      nvec++; if (rdata0 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL rd_data: got %h want deadbeef", rdata0); end
      tick;
      nvec++; if (rdata0 !== 32'h0) begin nerr++; $display("FAIL rd_idle_zero: got %h want 0", rdata0); end
   endtask

   task automatic test_byte_lanes;
      drive(0, 32'h10, 1'b1, 3'd2);
      tick;
      hwdata = 32'h1122_3344;
      drive(0, 32'h13, 1'b1, 3'd0);
      tick;
      hwdata = 32'hAA55_5555;
      drive(0, 32'h10, 1'b1, 3'd1);
      nvec++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL bl_ready: got %b want 1", ready0); end
      tick;
      hwdata = 32'h9999_5678;
      drive(0, 32'h10, 1'b0, 3'd2);
      tick;
      idle();
      nvec++; if (rdata0 !== 32'hAA22_5678) begin nerr++; $display("FAIL bl_data: got %h want aa225678", rdata0); end
      tick;
   endtask

   task automatic test_back_to_back;
      logic        w [6];
      logic [31:0] a [6];
      logic [31:0] d [6];
      w = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      a = '{32'h20, 32'h24, 32'h28, 32'h28, 32'h20, 32'h24};
      d = '{32'h0101_2020, 32'h0202_2424, 32'h0303_2828,
            32'h0303_2828, 32'h0101_2020, 32'h0202_2424};
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) drive(0, a[i], w[i], 3'd2);
         else       idle();
         if (i > 0) begin
            nvec++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ready0); end
            if (w[i-1]) hwdata = d[i-1];
            else begin
               nvec++; if (rdata0 !== d[i-1]) begin nerr++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rdata0, d[i-1]); end
            end
         end
         tick;
      end
   endtask

   task automatic test_wait_states;
      int n;
      drive(3, 32'h2000_0040, 1'b1, 3'd2);
      tick;
      hwdata = 32'h1234_5678;
      idle();
      n = 0;
      while (ready3 === 1'b0 && n < 10) begin n++; tick; end
      nvec++; if (n != 3) begin nerr++; $display("FAIL ws_wr_cycles: got %0d want 3", n); end
      nvec++; if (resp3 !== 1'b0) begin nerr++; $display("FAIL ws_wr_resp: got %b want 0", resp3); end
      tick;
      drive(3, 32'h2000_0040, 1'b0, 3'd2);
      tick;
      idle();
      n = 0;
      while (ready3 === 1'b0 && n < 10) begin
         nvec++; if (rdata3 !== 32'h0) begin nerr++; $display("FAIL ws_rd_wait_zero: got %h want 0", rdata3); end
         n++;
         tick;
      end
      nvec++; if (n != 3) begin nerr++; $display("FAIL ws_rd_cycles: got %0d want 3", n); end
      nvec++; if (resp3 !== 1'b0) begin nerr++; $display("FAIL ws_rd_resp: got %b want 0", resp3); end
      nvec++; if (rdata3 !== 32'h1234_5678) begin nerr++; $display("FAIL ws_rd_data: got %h want 12345678", rdata3); end
      tick;
   endtask

   task automatic test_oob_error;
      drive(0, 32'h0, 1'b1, 3'd2);
      tick;
      hwdata = 32'hCAFE_F00D;
      drive(0, 32'hFFC, 1'b1, 3'd2);
      tick;
      hwdata = 32'h0BAD_C0DE;
      drive(0, 32'h1000, 1'b1, 3'd2);
      tick;
      hwdata = 32'hFFFF_FFFF;
      idle();
      nvec++; if (ready0 !== 1'b0) begin nerr++; $display("FAIL oob_err1_ready: got %b want 0", ready0); end
      nvec++; if (resp0 !== 1'b1) begin nerr++; $display("FAIL oob_err1_resp: got %b want 1", resp0); end
      nvec++; if (rdata0 !== 32'h0) begin nerr++; $display("FAIL oob_err1_rdata: got %h want 0", rdata0); end
      tick;
      nvec++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL oob_err2_ready: got %b want 1", ready0); end
      nvec++; if (resp0 !== 1'b1) begin nerr++; $display("FAIL oob_err2_resp: got %b want 1", resp0); end
      tick;
      nvec++; if (resp0 !== 1'b0) begin nerr++; $display("FAIL oob_after_resp: got %b want 0", resp0); end
      drive(0, 32'h0, 1'b0, 3'd2);
      tick;
      drive(0, 32'hFFC, 1'b0, 3'd2);
      nvec++; if (rdata0 !== 32'hCAFE_F00D) begin nerr++; $display("FAIL oob_word0: got %h want cafef00d", rdata0); end
      tick;
      idle();
      nvec++; if (rdata0 !== 32'h0BAD_C0DE) begin nerr++; $display("FAIL oob_lastword: got %h want 0badc0de", rdata0); end
      tick;
      // doubleword on a 32-bit bus is oversize
      drive(0, 32'h10, 1'b0, 3'd3);
      tick;
      idle();
      nvec++; if (resp0 !== 1'b1 || ready0 !== 1'b0) begin nerr++; $display("FAIL size_err: got resp %b ready %b want 1 0", resp0, ready0); end
      tick; tick;
      drive(3, 32'h1FFF_FFFC, 1'b0, 3'd2);
      tick;
      idle();
      nvec++; if (resp3 !== 1'b1 || ready3 !== 1'b0) begin nerr++; $display("FAIL below_base_err1: got resp %b ready %b want 1 0", resp3, ready3); end
      tick;
      nvec++; if (resp3 !== 1'b1 || ready3 !== 1'b1) begin nerr++; $display("FAIL below_base_err2: got resp %b ready %b want 1 1", resp3, ready3); end
      tick;
   endtask

   task automatic test_misaligned;
      hwdata = 32'hFFFF_FFFF;
      drive(0, 32'h1, 1'b1, 3'd1);
      tick;
      idle();
      nvec++; if (ready0 !== 1'b0 || resp0 !== 1'b1) begin nerr++; $display("FAIL mis_err1: got ready %b resp %b want 0 1", ready0, resp0); end
      tick;
      nvec++; if (ready0 !== 1'b1 || resp0 !== 1'b1) begin nerr++; $display("FAIL mis_err2: got ready %b resp %b want 1 1", ready0, resp0); end
      drive(0, 32'h10, 1'b0, 3'd2);
      tick;
      idle();
      nvec++; if (ready0 !== 1'b1 || resp0 !== 1'b0) begin nerr++; $display("FAIL mis_next_okay: got ready %b resp %b want 1 0", ready0, resp0); end
      nvec++; if (rdata0 !== 32'hAA22_5678) begin nerr++; $display("FAIL mis_next_data: got %h want aa225678", rdata0); end
      tick;
      drive(0, 32'h0, 1'b0, 3'd2);
      tick;
      idle();
      nvec++; if (rdata0 !== 32'hCAFE_F00D) begin nerr++; $display("FAIL mis_word0_intact: got %h want cafef00d", rdata0); end
      tick;
   endtask

   task automatic test_reset_mid_write;
      int n;
      drive(3, 32'h2000_0040, 1'b1, 3'd2);
      tick;
      hwdata = 32'hFFFF_0000;
      idle();
      tick;
      rst_n = 1'b0;
      #1;
      nvec++; if (ready3 !== 1'b1) begin nerr++; $display("FAIL rstw_ready: got %b want 1", ready3); end
      nvec++; if (resp3 !== 1'b0) begin nerr++; $display("FAIL rstw_resp: got %b want 0", resp3); end
      nvec++; if (rdata3 !== 32'h0) begin nerr++; $display("FAIL rstw_rdata: got %h want 0", rdata3); end
      tick; tick; tick;
      rst_n = 1'b1;
      drive(3, 32'h2000_0040, 1'b0, 3'd2);
      tick;
      idle();
      n = 0;
      while (ready3 === 1'b0 && n < 10) begin n++; tick; end
      nvec++; if (n != 3) begin nerr++; $display("FAIL rstw_first_cycles: got %0d want 3", n); end
      nvec++; if (rdata3 !== 32'h1234_5678) begin nerr++; $display("FAIL rstw_old_word: got %h want 12345678", rdata3); end
      tick;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_back_to_back();
      test_wait_states();
      test_oob_error();
      test_misaligned();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, HADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, HWDATA/HRDATA width; legal values 32 and 64.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, memory depth in DATA_WIDTH words; power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-005 SHALL have parameter WAIT_STATES, default 0, wait cycles per NONSEQ/SEQ data phase; range 0..7.
REQ-006 Ports, one clock; reset asynchronous, active-low:
  HCLK  in  1  clock, all state on rising edge
  HRESETn  in  1  asynchronous active-low reset
  HSEL  in  1  slave select
  HADDR  in  ADDR_WIDTH  byte address
  HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
  HWRITE  in  1  1=write
  HSIZE  in  3  transfer size, bytes=2**HSIZE
  HBURST  in  3  accepted, ignored
  HPROT  in  4  accepted, ignored
  HMASTLOCK  in  1  accepted, ignored
  HREADY  in  1  bus ready, previous data phase complete
  HWDATA  in  DATA_WIDTH  write data
  HREADYOUT  out  1  slave ready
  HRESP  out  1  0=OKAY, 1=ERROR
  HRDATA  out  DATA_WIDTH  read data

Function
REQ-007 Transfer accepted on rising edge with HSEL=1, HREADY=1, HTRANS[1]=1; address-phase signals registered at that edge.
REQ-008 IDLE/BUSY or HSEL=0 with HREADY=1 SHALL produce zero-wait OKAY data phase, no memory access.
REQ-009 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-010 IDLE: HREADYOUT=1, HRESP=0; on valid accepted transfer -> WAIT if WAIT_STATES>0, else remain IDLE and complete next cycle; on error transfer -> ERR1.
REQ-011 WAIT: HREADYOUT=0, HRESP=0, counter loaded with WAIT_STATES-1, decrements each cycle; at 0 -> IDLE, completing with HREADYOUT=1 next cycle.
REQ-012 Error transfer: offset (HADDR-BASE_ADDR) >= DEPTH_WORDS*DATA_WIDTH/8 (incl. HADDR<BASE_ADDR), or 2**HSIZE > DATA_WIDTH/8, or HADDR not aligned to 2**HSIZE.
REQ-013 ERR1: HREADYOUT=0, HRESP=1 for one cycle -> ERR2: HREADYOUT=1, HRESP=1 for one cycle -> IDLE; no wait states on error; memory untouched.
REQ-014 Transfer accepted in ERR2 cycle SHALL be processed normally.
REQ-015 Word index = offset[log2(DEPTH_WORDS)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
REQ-016 Write: HWDATA sampled and committed on the edge ending the data phase (HREADYOUT=1); only byte lanes selected by HSIZE and low address bits written, little-endian.
REQ-017 Read: HRDATA SHALL carry full word at the index when HREADYOUT=1 in data phase; non-selected lanes carry memory contents.
REQ-018 Read whose data phase follows a write to the same word SHALL return the written bytes (no RAW hazard).
REQ-019 HRDATA SHALL be 0 outside read data phases and in error responses.
REQ-020 Back-to-back pipelined transfers with WAIT_STATES=0 SHALL sustain one transfer per cycle.

Reset
REQ-021 HRESETn low SHALL immediately force HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, counter=0.
REQ-022 Transfer in progress at reset SHALL be dropped; uncommitted write not performed.
REQ-023 Memory contents SHALL not be cleared by reset.
REQ-024 First transfer accepted on first rising edge after HRESETn deasserts.

Verification
REQ-025 WAIT_STATES=0: write word 0xDEADBEEF to 0x10, read 0x10 next cycle -> HRDATA=0xDEADBEEF, HREADYOUT never low.
REQ-026 DATA_WIDTH=32: byte write 0xAA to 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-027 WAIT_STATES=3: read -> HREADYOUT low exactly 3 cycles, OKAY, data valid on 4th data-phase cycle.
REQ-028 DEPTH_WORDS=1024, DATA_WIDTH=32: NONSEQ to BASE_ADDR+0x1000 -> HREADYOUT 0/1, HRESP 1/1 over two cycles, memory unchanged.
REQ-029 Halfword to 0x01 (misaligned) -> two-cycle ERROR; NONSEQ issued in ERR2 cycle completes OKAY.
REQ-030 HRESETn low during WAIT cycle 2 of a write -> outputs at reset values same cycle, target word keeps old value.
